ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM/requester address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter BURST_MAX, default 4, max consecutive locked DMA grants (range 1..15).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have ports cpu_req, cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): CPU request, write flag, address and write data.
REQ-007 SHALL have ports cpu_ack (output, 1), one-cycle completion pulse, and cpu_rdata (output, DATA_W), read data valid with cpu_ack.
REQ-008 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_ack and dma_rdata, the same as the CPU set, plus dma_lock (input, 1), burst hold request.
REQ-009 SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, DATA_W), ram_we (output, 1) and ram_rdata (input, DATA_W, combinational read of ram_addr).

Function
REQ-010 SHALL implement FSM states IDLE, ACC_CPU, ACC_DMA, RSP_CPU, RSP_DMA.
REQ-011 IDLE: SHALL sample cpu_req/dma_req; next state is ACC_x of the winner; with no request, stay IDLE.
REQ-012 ACC_x: SHALL latch the winner's addr/wdata/we at grant; SHALL drive ram_* from the latched values for exactly one cycle, with ram_we=latched we; next state RSP_x.
REQ-013 SHALL capture ram_rdata into x_rdata at the end of ACC_x; x_rdata SHALL hold until the next access by the same requester.
REQ-014 RSP_x: SHALL pulse x_ack for one cycle; ram_we=0; requests are not sampled; next state IDLE, except per REQ-017.
REQ-015 Latency: request seen in IDLE at cycle N -> ram access at N+1 -> ack at N+2; throughput is one access per 3 cycles.
REQ-016 Handshake: the requester SHALL hold req/addr/wdata/we stable until ack. req still high in the cycle after ack is a new request.
REQ-017 Lock: in RSP_DMA with dma_lock=1, dma_req=1 and burst_cnt<BURST_MAX, the next state SHALL be ACC_DMA, skipping IDLE, and the DMA inputs are latched in that transition.
REQ-018 burst_cnt SHALL increment on each ACC_DMA entry, saturate at BURST_MAX, and clear on any ACC_CPU entry or on entry to IDLE with dma_lock=0.
REQ-019 When burst_cnt=BURST_MAX, the DMA SHALL pass through IDLE; there a pending cpu_req SHALL win regardless of the arbitration mode.
REQ-020 Outside ACC_x, ram_we SHALL be 0; ram_addr/ram_wdata hold their last values.
REQ-021 An access with addr in the display window (0xC000..0xF000) SHALL be sequenced identically; the arbiter does not decode addresses.

Reset
REQ-022 With rst_n=0 at a clock edge, SHALL force state IDLE, burst_cnt=0, last-grant=DMA (CPU favoured first), all acks=0, ram_we=0, and ram_addr, ram_wdata, cpu_rdata, dma_rdata=0.
REQ-023 Reset during ACC_x or RSP_x SHALL abort the access: no ack is issued and ram_we=0 from the reset cycle.

Configuration
REQ-024 Macro RAM_ARB_RR_EN defined: a tie in IDLE SHALL go to the requester not granted last (round-robin).
REQ-025 Macro RAM_ARB_RR_EN undefined: a tie SHALL always go to the CPU (fixed priority); the last-grant register is removed.
REQ-026 The lock and burst limit (REQ-017..019) SHALL apply in both modes.

Structure
REQ-027 Package ram_arb_pkg SHALL hold the FSM state enum typedef, the display window constants DISP_BASE=0xC000 and DISP_TOP=0xF000, and the requester-id typedef.
REQ-028 A sub-module ram_arb_pick (combinational winner select from cpu_req, dma_req, last_grant and burst_full) SHALL be used; all sequencing stays in ram_arbiter.

Verification
REQ-029 CPU-only write: cpu_req, we=1, addr 0x0010, wdata 0xDEADBEEF at N -> ram_we=1, ram_addr=0x0010 at N+1 -> cpu_ack at N+2. A following read of 0x0010 returns 0xDEADBEEF.
REQ-030 Simultaneous requests for 4 rounds, RR build -> grants alternate CPU, DMA, CPU, DMA; fixed build -> CPU, CPU, CPU, CPU with dma_ack never asserted.
REQ-031 DMA burst: dma_lock=1, BURST_MAX=4, cpu_req also high -> exactly 4 back-to-back DMA accesses, each 2 cycles apart, then an IDLE cycle and a CPU grant.
REQ-032 Display write: dma write to 0xC123, data 0x00FF00 -> ram_addr=0xC123 and ram_we=1 for exactly one cycle, then dma_ack.
REQ-033 Reset mid-access: rst_n=0 in ACC_CPU -> no cpu_ack, ram_we=0 that cycle, state IDLE; after release a simultaneous request goes to the CPU.
REQ-034 Back-to-back: cpu_req held high across its ack with a new addr -> second access begins at ack+1 (IDLE sample) and completes 3 cycles after the first ack.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the CPU/DMA single-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_CPU = 3'd1,
        ACC_DMA = 3'd2,
        RSP_CPU = 3'd3,
        RSP_DMA = 3'd4
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // Display window; accesses here are sequenced like any other address.
    localparam logic [15:0] DISP_BASE = 16'hC000;
    localparam logic [15:0] DISP_TOP  = 16'hF000;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the IDLE grant decision.
// RAM_ARB_RR_EN selects round-robin tie breaking; otherwise the CPU wins ties.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic    i_cpu_req,
    input  logic    i_dma_req,
    input  req_id_t i_last_grant,
    input  logic    i_burst_full,
    output logic    o_gnt_vld,
    output req_id_t o_gnt_id
);

`ifdef RAM_ARB_RR_EN
    always_comb begin
        o_gnt_vld = i_cpu_req | i_dma_req;
        o_gnt_id  = REQ_CPU;
        if (!i_cpu_req)
            o_gnt_id = REQ_DMA;
        // A DMA that just used up its burst must yield to a waiting CPU.
        else if (i_dma_req && !i_burst_full)
            o_gnt_id = (i_last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end
`else
    logic [1:0] w_unused_pick;
    assign w_unused_pick = {i_last_grant, i_burst_full};

    always_comb begin
        o_gnt_vld = i_cpu_req | i_dma_req;
        o_gnt_id  = i_cpu_req ? REQ_CPU : REQ_DMA;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single-port RAM with DMA burst lock.
// Define RAM_ARB_RR_EN for round-robin ties; default build is fixed CPU priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t              r_state, w_nxt;
    logic [3:0]          r_burst_cnt;
    logic                r_cpu_ack, r_dma_ack, r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata, r_cpu_rdata, r_dma_rdata;
    logic                w_burst_full, w_gnt_vld;
    req_id_t             w_gnt_id, w_last;

    assign w_burst_full = (r_burst_cnt == 4'(BURST_MAX));

`ifdef RAM_ARB_RR_EN
    req_id_t r_last_grant;
    assign w_last = r_last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_grant <= REQ_DMA;
        else if (w_nxt == ACC_CPU)
            r_last_grant <= REQ_CPU;
        else if (w_nxt == ACC_DMA)
            r_last_grant <= REQ_DMA;
    end
`else
    assign w_last = REQ_DMA;
`endif

    ram_arb_pick u_pick (
        .i_cpu_req    (cpu_req),
        .i_dma_req    (dma_req),
        .i_last_grant (w_last),
        .i_burst_full (w_burst_full),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt_id     (w_gnt_id)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_nxt = (w_gnt_id == REQ_CPU) ? ACC_CPU : ACC_DMA;
            ACC_CPU: w_nxt = RSP_CPU;
            ACC_DMA: w_nxt = RSP_DMA;
            RSP_CPU: w_nxt = IDLE;
            RSP_DMA: w_nxt = (dma_lock && dma_req && !w_burst_full) ? ACC_DMA : IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= 4'd0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_state   <= w_nxt;
            r_cpu_ack <= (r_state == ACC_CPU);
            r_dma_ack <= (r_state == ACC_DMA);
            r_ram_we  <= 1'b0;
            if (w_nxt == ACC_CPU) begin
                r_ram_addr  <= cpu_addr;
                r_ram_wdata <= cpu_wdata;
                r_ram_we    <= cpu_we;
                r_burst_cnt <= 4'd0;
            end else if (w_nxt == ACC_DMA) begin
                r_ram_addr  <= dma_addr;
                r_ram_wdata <= dma_wdata;
                r_ram_we    <= dma_we;
                if (!w_burst_full)
                    r_burst_cnt <= r_burst_cnt + 4'd1;
            end else if (w_nxt == IDLE && r_state != IDLE && !dma_lock) begin
                r_burst_cnt <= 4'd0;
            end
            if (r_state == ACC_CPU) r_cpu_rdata <= ram_rdata;
            if (r_state == ACC_DMA) r_dma_rdata <= ram_rdata;
        end
    end

    // Reset cuts the write strobe immediately so an aborted access never lands.
    assign ram_we    = r_ram_we & rst_n;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;

endmodule
